// File: rtl/block_spawner_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : game_pkg                                                           |
// | Brief   : Piece types, spawner FSM states and LFSR helpers for block_spawner |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
package game_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_t;

    localparam int          NUM_PIECES = 7;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_OFFER = 2'd2
    } spawner_state_t;

    // Galois form: shift right, fold the ejected bit back through the taps.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_spawner_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : block_spawner_if                                                 |
// | Brief     : Request / spawn-offer / HUD preview bundle of block_spawner      |
// | Rev       : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface block_spawner_if #(
    parameter int QUEUE_DEPTH = 3
) ();
    logic                     new_block;
    logic                     spawn_ready;
    logic                     spawn_valid;
    logic [2:0]               spawn_type;
    logic [7:0]               spawn_id;
    logic [3*QUEUE_DEPTH-1:0] next_types;
    logic [1:0]               pending;
    logic                     overflow;

    modport master (
        input  new_block, spawn_ready,
        output spawn_valid, spawn_type, spawn_id, next_types, pending, overflow
    );

    modport slave (
        output new_block, spawn_ready,
        input  spawn_valid, spawn_type, spawn_id, next_types, pending, overflow
    );
endinterface
`default_nettype wire

// File: rtl/block_spawner_bag_rng.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : piece_bag_rng                                                       |
// | Brief  : 16-bit Galois LFSR feeding a 7-bag; type is combinational on state |
// | Rev    : 1.0  initial release                                                |
// +-----------------------------------------------------------------------------+
module piece_bag_rng
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  wire logic   frame_clk,
    input  wire logic   Reset,
    input  wire logic   draw_i,
    output piece_t      type_o
);
    logic [15:0] lfsr_q;
    logic [6:0]  bag_q;
    logic [6:0]  bag_d;
    logic [2:0]  w_idx;
    logic [2:0]  w_pick;
    logic [2:0]  w_pos;
    logic        w_found;

    assign w_idx = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];

    // Circular scan from idx; the bag is never empty so a hit always exists.
    always_comb begin
        w_pick  = 3'd0;
        w_found = 1'b0;
        w_pos   = 3'd0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            w_pos = 3'((int'(w_idx) + k) % NUM_PIECES);
            if (!w_found && bag_q[w_pos]) begin
                w_pick  = w_pos;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        bag_d = bag_q;
        if (draw_i) begin
            bag_d[w_pick] = 1'b0;
            if (bag_d == 7'h00) begin
                bag_d = 7'h7F;
            end
        end
    end

    assign type_o = piece_t'(w_pick);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            lfsr_q <= LFSR_SEED;
            bag_q  <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            bag_q  <= bag_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/block_spawner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : block_spawner                                                       |
// | Brief  : Turns new_block strobes into spawn offers from a 7-bag preview queue|
// | Rev    : 1.0  initial release                                                |
// +-----------------------------------------------------------------------------+
module block_spawner
    import game_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          PEND_MAX    = 3
) (
    input  wire logic          frame_clk,
    input  wire logic          Reset,
    block_spawner_if.master    bus
);
    localparam int         FILL_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [1:0] PEND_SAT = 2'(PEND_MAX);

    spawner_state_t    state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [2:0]        queue_q [QUEUE_DEPTH];
    logic [2:0]        queue_d [QUEUE_DEPTH];
    logic [2:0]        type_q, type_d;
    logic [7:0]        id_q, id_d;
    logic [1:0]        pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              w_transfer;
    logic              w_draw;
    piece_t            w_new_type;

    piece_bag_rng #(.LFSR_SEED(LFSR_SEED)) u_bag (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .draw_i    (w_draw),
        .type_o    (w_new_type)
    );

    assign w_transfer = (state_q == ST_OFFER) && bus.spawn_ready;
    assign w_draw     = (state_q == ST_FILL) || w_transfer;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        type_d  = type_q;
        id_d    = id_q;
        case (state_q)
            ST_FILL: begin
                fill_d = fill_q + 1'b1;
                if (fill_q == FILL_W'(QUEUE_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    fill_d  = '0;
                end
            end
            ST_IDLE: begin
                if (pend_q != 2'd0) begin
                    state_d = ST_OFFER;
                    type_d  = queue_q[0];
                end
            end
            ST_OFFER: begin
                if (w_transfer) begin
                    state_d = ST_IDLE;
                    id_d    = id_q + 8'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Every draw shifts toward the head and lands the new type at the tail.
    always_comb begin
        queue_d = queue_q;
        if (w_draw) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                queue_d[i] = queue_q[i + 1];
            end
            queue_d[QUEUE_DEPTH - 1] = w_new_type;
        end
    end

    // A strobe coinciding with a transfer cancels out and cannot overflow.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (bus.new_block && !w_transfer) begin
            if (pend_q == PEND_SAT) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (!bus.new_block && w_transfer) begin
            pend_d = pend_q - 2'd1;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            type_q  <= 3'd0;
            id_q    <= 8'd0;
            pend_q  <= 2'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= 3'd0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            type_q  <= type_d;
            id_q    <= id_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            queue_q <= queue_d;
        end
    end

    generate
        for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_preview
            assign bus.next_types[3*g +: 3] = queue_q[g];
        end
    endgenerate

    assign bus.spawn_valid = (state_q == ST_OFFER);
    assign bus.spawn_type  = type_q;
    assign bus.spawn_id    = id_q;
    assign bus.pending     = pend_q;
    assign bus.overflow    = ovf_q;
endmodule
`default_nettype wire
